segtohex_capture: RTL
=====================

Name: segtohex_capture

Overview:
- Reader side of the team's multiplexed 7-segment display bus: samples active-low segment lines plus active-low digit enables and recovers the hex value shown on each digit.
- Filters scan glitches and blanking gaps, keeps a per-digit value/error snapshot, and reports each change as an event on a valid/ready port.
- Used by board self-test and by verification monitors that check display drivers.

Parameters:
DIGITS, 4, number of scanned digits (1..8); DW = max(1, $clog2(DIGITS))
STABLE_CYCLES, 3, consecutive identical samples required before a pattern is accepted (2..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
seg_n  in  7  segment lines, active-low; bit0=a ... bit6=g
an_n  in  DIGITS  digit enables, active-low
out_valid  out  1  event pending
out_ready  in  1  consumer accepts event when out_valid&&out_ready
out_digit  out  DW  digit index of event (an_n bit position)
out_hex  out  4  decoded value of event
out_err  out  1  event pattern not a legal code
out_drop  out  1  one-cycle pulse: pending event overwritten
value  out  4*DIGITS  snapshot; digit i in bits [4i+3:4i]
err_mask  out  DIGITS  bit i = last accepted pattern on digit i was illegal

Behaviour:
- Reset: out_valid=0, out_digit=0, out_hex=0, out_err=0, out_drop=0, value=0, err_mask=0, seen bits=0, run counter=0, accepted flag=0, input sample register=all-ones (dark, no digit). Reset mid-event discards the pending event with no drop pulse.
- Stage 1: {an_n, seg_n} registered every cycle into the sample register.
- Stage 2: run counter increments (saturating at STABLE_CYCLES) while the new sample equals the previous one; clears to 0 on any difference, which also clears the accepted flag.
- Acceptance: once per stable window, when the counter reaches STABLE_CYCLES-1, the accepted flag is 0, and exactly one an_n bit is low. Zero or several low bits mean blanking/overlap: ignored, no state change.
- Decode on lit = ~seg_n: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F. Any other pattern gives hex=0 and err=1.
- Update on acceptance: value slice and err_mask bit written; an event is generated if the seen bit is 0, hex differs, or err differs; the seen bit is then set.
- Latency: pattern steady on pins before edge 0 -> out_valid high after edge STABLE_CYCLES+1.
- Output register: single entry. Event loads on the edge after acceptance. Handshake pops the entry; a simultaneous pop and new event loads the new event and out_valid stays 1. A new event while out_valid&&!out_ready overwrites the entry (newest wins) and pulses out_drop for 1 cycle.
- out_digit/out_hex/out_err are held stable while out_valid&&!out_ready unless overwritten.

Optional Feature:
- Macro BLANK_DETECT_EN.
- Defined: adds output port blank_mask [DIGITS-1:0], reset 0. An all-dark pattern (seg_n=7'h7F) on a single enabled digit is legal. It sets blank bit i, clears err bit i, sets value slice to 0, and emits an event with out_hex=0, out_err=0 when the blank bit changes. Any legal code clears blank bit i.
- Undefined: no blank_mask port; the all-dark pattern is illegal (err=1).

Test Plan:
1. Reset, then idle inputs (all ones) for 20 cycles -> out_valid=0, value=0, err_mask=0 throughout.
2. an_n=4'b1110, seg_n=7'h40 held; out_ready=1 -> one event (digit 0, hex 0, err 0) after edge 4. Re-hold the same pattern after an_n=4'b1111 gap -> no new event.
3. an_n=4'b1011, seg_n=7'h08 (A) held 2 cycles, then an_n=4'b1111 -> no event, value unchanged.
4. an_n=4'b0111, seg_n=7'h7E (lit 01) held 5 cycles -> event digit 3, out_err=1, err_mask=4'b1000, value[15:12]=0.
5. out_ready=0: digit1 seg_n=7'h79 (1), then digit2 seg_n=7'h00 (8) -> out_drop pulse, pending event = digit 2 hex 8. an_n=4'b1100 with any seg_n -> ignored.
6. With BLANK_DETECT_EN: digit0 shows 5 (seg_n=7'h12), then seg_n=7'h7F -> blank_mask[0]=1, event hex 0 err 0. Without the macro, the same stimulus gives err_mask[0]=1.

Source files
------------

// File: rtl/segtohex_capture.sv
// segtohex_capture
// Reader for a multiplexed 7-segment display bus. It samples the active-low
// segment lines and digit enables, waits for a pattern to hold steady, and
// decodes the hex value shown on the enabled digit. It keeps a per-digit
// value and error snapshot and reports every change as an event on a
// single-entry valid/ready port.
//
// Optional feature macro: BLANK_DETECT_EN
//   When defined, an all-dark pattern on a single enabled digit is treated
//   as a legal "blank" and reported on blank_mask. When undefined, the
//   all-dark pattern is an illegal code.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   seg_n      segment lines a..g (bit0 = a), active-low
//   an_n       digit enables, active-low
//   out_valid  event pending
//   out_ready  consumer accepts the event when out_valid && out_ready
//   out_digit  digit index of the event
//   out_hex    decoded value of the event
//   out_err    event pattern was not a legal code
//   out_drop   one-cycle pulse: a pending event was overwritten
//   value      snapshot, digit i in bits [4i+3:4i]
//   err_mask   bit i set when the last accepted pattern on digit i was illegal
//   blank_mask (BLANK_DETECT_EN only) bit i set when digit i is blank
module segtohex_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3,
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_n,
  input  logic [DIGITS-1:0]   an_n,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_digit,
  output logic [3:0]          out_hex,
  output logic                out_err,
  output logic                out_drop,
  output logic [4*DIGITS-1:0] value,
`ifdef BLANK_DETECT_EN
  output logic [DIGITS-1:0]   blank_mask,
`endif
  output logic [DIGITS-1:0]   err_mask
);

  localparam int SW = DIGITS + 7;

  logic [SW-1:0]     samp;
  logic [SW-1:0]     prev;
  logic [7:0]        run_cnt;
  logic              accepted;
  logic [DIGITS-1:0] seen;

  logic [DIGITS-1:0] lo;
  logic              one_hot;
  logic [DW-1:0]     idx;
  logic [6:0]        lit;
  logic [3:0]        dec_hex;
  logic              dec_err;
  logic              dec_blank;
  logic              eq;
  logic              accept;
  logic              ev;

  always_comb begin
    lo      = ~samp[SW-1:7];
    one_hot = (lo != '0) && ((lo & (lo - 1'b1)) == '0);
    idx     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (lo[i]) idx = DW'(i);
    end
  end

  always_comb begin
    lit       = ~samp[6:0];
    dec_hex   = 4'h0;
    dec_err   = 1'b0;
    dec_blank = 1'b0;
    case (lit)
      7'h3F: dec_hex = 4'h0;
      7'h06: dec_hex = 4'h1;
      7'h5B: dec_hex = 4'h2;
      7'h4F: dec_hex = 4'h3;
      7'h66: dec_hex = 4'h4;
      7'h6D: dec_hex = 4'h5;
      7'h7D: dec_hex = 4'h6;
      7'h07: dec_hex = 4'h7;
      7'h7F: dec_hex = 4'h8;
      7'h6F: dec_hex = 4'h9;
      7'h77: dec_hex = 4'hA;
      7'h7C: dec_hex = 4'hB;
      7'h39: dec_hex = 4'hC;
      7'h5E: dec_hex = 4'hD;
      7'h79: dec_hex = 4'hE;
      7'h71: dec_hex = 4'hF;
`ifdef BLANK_DETECT_EN
      7'h00: dec_blank = 1'b1;
`endif
      default: dec_err = 1'b1;
    endcase
  end

  // The counter shows how many compares in a row matched, ending at the
  // previous cycle. Requiring eq in the current cycle as well keeps a
  // pattern that changed one cycle early from being accepted.
  assign eq     = (samp == prev);
  assign accept = one_hot && eq && !accepted &&
                  (run_cnt == 8'(STABLE_CYCLES - 1));

`ifdef BLANK_DETECT_EN
  assign ev = accept && (!seen[idx] || (value[4*idx +: 4] != dec_hex) ||
                         (err_mask[idx] != dec_err) ||
                         (blank_mask[idx] != dec_blank));
`else
  assign ev = accept && (!seen[idx] || (value[4*idx +: 4] != dec_hex) ||
                         (err_mask[idx] != dec_err));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      samp       <= '1;
      prev       <= '1;
      run_cnt    <= '0;
      accepted   <= 1'b0;
      seen       <= '0;
      value      <= '0;
      err_mask   <= '0;
`ifdef BLANK_DETECT_EN
      blank_mask <= '0;
`endif
      out_valid  <= 1'b0;
      out_digit  <= '0;
      out_hex    <= '0;
      out_err    <= 1'b0;
      out_drop   <= 1'b0;
    end else begin
      samp     <= {an_n, seg_n};
      prev     <= samp;
      out_drop <= 1'b0;

      if (eq) begin
        if (run_cnt != 8'(STABLE_CYCLES)) run_cnt <= run_cnt + 8'd1;
      end else begin
        run_cnt  <= '0;
        accepted <= 1'b0;
      end

      if (accept) begin
        accepted           <= 1'b1;
        seen[idx]          <= 1'b1;
        value[4*idx +: 4]  <= dec_hex;
        err_mask[idx]      <= dec_err;
`ifdef BLANK_DETECT_EN
        blank_mask[idx]    <= dec_blank;
`endif
      end

      // Single entry: newest event wins; overwriting an unaccepted entry
      // is flagged on out_drop.
      if (ev) begin
        out_valid <= 1'b1;
        out_digit <= idx;
        out_hex   <= dec_hex;
        out_err   <= dec_err;
        out_drop  <= out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
